// File: rtl/tm1637_frame_sequencer.sv
// TM1637 display refresh sequencer: bit-bangs the data-command, address+digits and
// display-control transactions with start/stop framing and ACK checking.
module tm1637_frame_sequencer #(
    parameter int CLK_DIV = 250
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] seg_data,
    input  logic [2:0]  bright,
    input  logic        disp_on,
    input  logic        tm1637_dio_in,
    output logic        tm1637_clk,
    output logic        tm1637_dio_oe,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic [6:0]  debug_step_id
);

    localparam int              DIVW     = $clog2(CLK_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [1:0] PH_START = 2'd0;
    localparam logic [1:0] PH_DATA  = 2'd1;
    localparam logic [1:0] PH_ACK   = 2'd2;
    localparam logic [1:0] PH_STOP  = 2'd3;

    localparam logic [6:0] DBG_IDLE = 7'h7F;

    // Byte sent at position idx of transaction txn.
    function automatic logic [7:0] frame_byte(input logic [1:0]  txn,
                                              input logic [2:0]  idx,
                                              input logic [31:0] seg,
                                              input logic [2:0]  br,
                                              input logic        on);
        logic [7:0] b;
        b = 8'h00;
        case (txn)
            2'd0: b = 8'h40;
            2'd1: begin
                case (idx)
                    3'd0:    b = 8'hC0;
                    3'd1:    b = seg[7:0];
                    3'd2:    b = seg[15:8];
                    3'd3:    b = seg[23:16];
                    3'd4:    b = seg[31:24];
                    default: b = 8'h00;
                endcase
            end
            2'd2:    b = on ? (8'h88 | {5'b00000, br}) : 8'h80;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] txn);
        return (txn == 2'd1) ? 3'd4 : 3'd0;
    endfunction

    function automatic logic [1:0] phase_code(input logic [2:0] st);
        logic [1:0] p;
        case (st)
            ST_START: p = PH_START;
            ST_DATA:  p = PH_DATA;
            ST_ACK:   p = PH_ACK;
            ST_STOP:  p = PH_STOP;
            default:  p = PH_STOP;
        endcase
        return p;
    endfunction

    logic [DIVW-1:0] div_q, div_d;
    logic [2:0]      state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [1:0]      txn_q, txn_d;
    logic [31:0]     seg_q, seg_d;
    logic [2:0]      bright_q, bright_d;
    logic            disp_on_q, disp_on_d;
    logic            scl_q, scl_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic [6:0]      dbg_q, dbg_d;

    logic            tick_s;
    logic [7:0]      cur_byte_s;
    logic            cur_bit_s;

    assign tick_s     = busy_q && (div_q == DIV_LAST);
    assign cur_byte_s = frame_byte(txn_q, byte_q, seg_q, bright_q, disp_on_q);
    assign cur_bit_s  = cur_byte_s[bit_q];

    // Bus tick divider, running only while a frame is in progress.
    always_comb begin
        div_d = div_q;
        if (!busy_q) begin
            div_d = {DIVW{1'b0}};
        end else if (tick_s) begin
            div_d = {DIVW{1'b0}};
        end else begin
            div_d = div_q + {{(DIVW-1){1'b0}}, 1'b1};
        end
    end

    // Frame FSM: accept in IDLE, otherwise advance pins and step counters on each tick.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        txn_d     = txn_q;
        seg_d     = seg_q;
        bright_d  = bright_q;
        disp_on_d = disp_on_q;
        scl_d     = scl_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        dbg_d     = dbg_q;

        if (state_q == ST_IDLE) begin
            // The done cycle is still IDLE but must not accept a new frame.
            if (req && !done_q) begin
                seg_d     = seg_data;
                bright_d  = bright;
                disp_on_d = disp_on;
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
                state_d   = ST_START;
                step_d    = 2'd0;
                bit_d     = 3'd0;
                byte_d    = 3'd0;
                txn_d     = 2'd0;
            end else begin
                busy_d = 1'b0;
            end
        end else if (tick_s) begin
            dbg_d = {txn_q, byte_q, phase_code(state_q)};
            case (state_q)
                ST_START: begin
                    if (step_q == 2'd0) begin
                        scl_d  = 1'b1;
                        oe_d   = 1'b0;
                        step_d = 2'd1;
                    end else begin
                        oe_d    = 1'b1;
                        step_d  = 2'd0;
                        bit_d   = 3'd0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (step_q == 2'd0) begin
                        scl_d  = 1'b0;
                        oe_d   = ~cur_bit_s;
                        step_d = 2'd1;
                    end else begin
                        scl_d  = 1'b1;
                        step_d = 2'd0;
                        if (bit_q == 3'd7) begin
                            state_d = ST_ACK;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (step_q == 2'd0) begin
                        scl_d  = 1'b0;
                        oe_d   = 1'b0;
                        step_d = 2'd1;
                    end else begin
                        scl_d  = 1'b1;
                        step_d = 2'd0;
                        if (tm1637_dio_in) begin
                            ack_err_d = 1'b1;
                        end else begin
                            ack_err_d = ack_err_q;
                        end
                        if (byte_q == last_idx(txn_q)) begin
                            state_d = ST_STOP;
                        end else begin
                            byte_d  = byte_q + 3'd1;
                            bit_d   = 3'd0;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_STOP: begin
                    if (step_q == 2'd0) begin
                        scl_d  = 1'b0;
                        oe_d   = 1'b1;
                        step_d = 2'd1;
                    end else if (step_q == 2'd1) begin
                        scl_d  = 1'b1;
                        step_d = 2'd2;
                    end else begin
                        oe_d   = 1'b0;
                        step_d = 2'd0;
                        if (txn_q == 2'd2) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            dbg_d   = DBG_IDLE;
                        end else begin
                            txn_d   = txn_q + 2'd1;
                            byte_d  = 3'd0;
                            state_d = ST_START;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    scl_d   = 1'b1;
                    oe_d    = 1'b0;
                    dbg_d   = DBG_IDLE;
                end
            endcase
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            div_q     <= {DIVW{1'b0}};
            state_q   <= ST_IDLE;
            step_q    <= 2'd0;
            bit_q     <= 3'd0;
            byte_q    <= 3'd0;
            txn_q     <= 2'd0;
            seg_q     <= 32'h0000_0000;
            bright_q  <= 3'd0;
            disp_on_q <= 1'b0;
            scl_q     <= 1'b1;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            dbg_q     <= DBG_IDLE;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            step_q    <= step_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            txn_q     <= txn_d;
            seg_q     <= seg_d;
            bright_q  <= bright_d;
            disp_on_q <= disp_on_d;
            scl_q     <= scl_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            dbg_q     <= dbg_d;
        end
    end

    assign tm1637_clk    = scl_q;
    assign tm1637_dio_oe = oe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign ack_err       = ack_err_q;
    assign debug_step_id = dbg_q;

endmodule

// File: tb/tb_tm1637_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected frames/bytes, a pin-level monitor decodes
// the bus, emulates the slave ACK and compares against the queues.
module tb_tm1637_frame_sequencer;

    localparam int DIV     = 4;
    localparam int LATENCY = 141 * DIV + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] seg;
    logic [2:0]  br;
    logic        dsp;
    logic        dio_in;
    logic        scl, oe, busy, done, ack_err;
    logic [6:0]  dbg;

    always #5 clk = ~clk;

    tm1637_frame_sequencer #(.CLK_DIV(DIV)) dut (
        .clk_50M       (clk),
        .rst           (rst),
        .req           (req),
        .seg_data      (seg),
        .bright        (br),
        .disp_on       (dsp),
        .tm1637_dio_in (dio_in),
        .tm1637_clk    (scl),
        .tm1637_dio_oe (oe),
        .busy          (busy),
        .done          (done),
        .ack_err       (ack_err),
        .debug_step_id (dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int acc;
        bit nack;
    } frame_t;

    frame_t     frames_q[$];
    logic [7:0] bytes_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the seven bytes a frame carries, from the protocol rules.
    task automatic push_frame(input logic [31:0] s, input logic [2:0] b, input logic on,
                              input bit nk, input int acc);
        frame_t f;
        bytes_q.push_back(8'h40);
        bytes_q.push_back(8'hC0);
        for (int i = 0; i < 4; i++) bytes_q.push_back(s[8*i +: 8]);
        bytes_q.push_back(on ? 8'(136 + int'(b)) : 8'h80);
        f.acc  = acc;
        f.nack = nk;
        frames_q.push_back(f);
    endtask

    task automatic issue(input logic [31:0] s, input logic [2:0] b, input logic on, input bit nk);
        @(posedge clk); #1;
        seg = s; br = b; dsp = on; req = 1'b1;
        push_frame(s, b, on, nk, cyc);
        @(posedge clk); #1;
        req = 1'b0;
        seg = $urandom; br = 3'($urandom); dsp = 1'($urandom);
        check("accept_busy", busy, 1);
        check("accept_ack_clear", ack_err, 0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (frames_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timeout: actual pending %0d required 0", frames_q.size());
        end
    endtask

    // Monitor: decodes start/stop/bits, drives slave ACK, checks bytes and frame completion.
    initial begin : monitor
        logic       pscl, poe, pdone;
        logic [7:0] shreg;
        int         bitcnt, bytei, txn, starts, stops, nbytes;
        bit         ackexp, tgt;
        frame_t     f;
        dio_in = 1'b0;
        pscl = 1'b1; poe = 1'b0; pdone = 1'b0; shreg = 8'h00;
        bitcnt = 0; bytei = 0; txn = 0; starts = 0; stops = 0; nbytes = 0; ackexp = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                pscl = 1'b1; poe = 1'b0; pdone = 1'b0; dio_in = 1'b0;
                bitcnt = 0; bytei = 0; txn = 0; starts = 0; stops = 0; nbytes = 0; ackexp = 1'b0;
                continue;
            end
            if (pscl && scl && !poe && oe) begin
                starts++; bitcnt = 0; bytei = 0;
                if (txn == 0) ackexp = 1'b0;
            end else if (pscl && scl && poe && !oe) begin
                stops++; txn++; bitcnt = 0;
            end else if (!pscl && scl) begin
                bitcnt++;
                tgt = 1'b0;
                if (txn == 1 && bytei == 2 && frames_q.size() > 0) begin
                    if (frames_q[0].nack) tgt = 1'b1;
                end
                if (bitcnt <= 8) shreg[bitcnt-1] = ~oe;
                if (bitcnt == 8 && tgt) dio_in = 1'b1;
                if (bitcnt == 9) begin
                    dio_in = 1'b0;
                    if (tgt) ackexp = 1'b1;
                    check("ack_err_sticky", ack_err, ackexp);
                    check("debug_ack", dbg, {txn[1:0], bytei[2:0], 2'd2});
                    if (bytes_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_byte: actual %0h required none", shreg);
                    end else begin
                        check("byte", shreg, bytes_q.pop_front());
                    end
                    nbytes++; bytei++; bitcnt = 0;
                end
            end
            if (pdone) check("done_width", done, 0);
            if (done) begin
                if (frames_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: actual 1 required 0");
                end else begin
                    f = frames_q.pop_front();
                    check("latency", cyc - f.acc, LATENCY);
                    check("frame_ack_err", ack_err, f.nack);
                    check("starts", starts, 3);
                    check("stops", stops, 3);
                    check("bytes", nbytes, 7);
                    check("busy_at_done", busy, 0);
                    check("debug_idle", dbg, 7'h7F);
                    check("bus_idle", {scl, oe}, 2'b10);
                end
                txn = 0; starts = 0; stops = 0; nbytes = 0; bitcnt = 0;
            end
            pscl = scl; poe = oe; pdone = done;
        end
    end

    // Stimulus sequence.
    initial begin : stim
        int bad;
        bit seen;
        rst = 1'b1; req = 1'b0; seg = 32'h0; br = 3'd0; dsp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk", scl, 1);
        check("rst_oe", oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_debug", dbg, 7'h7F);
        rst = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (scl !== 1'b1 || oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg !== 7'h7F) bad++;
        end
        check("reset_hold_bad_cycles", bad, 0);

        issue(32'h3F06_5B4F, 3'd7, 1'b1, 1'b0);
        wait_idle();

        issue($urandom, 3'($urandom), 1'b1, 1'b1);
        wait_idle();

        issue($urandom, 3'd5, 1'b0, 1'b0);
        wait_idle();

        // A request during a frame is dropped.
        issue($urandom, 3'($urandom), 1'b1, 1'b0);
        repeat (98) @(posedge clk);
        #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        wait_idle();
        repeat (700) @(posedge clk);
        #1 check("lockout_idle", busy, 0);

        // Request held from the done cycle is taken one cycle later.
        issue($urandom, 3'($urandom), 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
        seg = $urandom; br = 3'($urandom); dsp = 1'b1; req = 1'b1;
        push_frame(seg, br, dsp, 1'b0, cyc + 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of txn1 data.
        issue($urandom, 3'($urandom), 1'b1, 1'b0);
        repeat (200) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_clk", scl, 1);
        check("midrst_oe", oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_debug", dbg, 7'h7F);
        frames_q.delete();
        bytes_q.delete();
        @(posedge clk); #2 rst = 1'b0;
        issue($urandom, 3'($urandom), 1'($urandom), 1'b0);
        wait_idle();

        for (int k = 0; k < 4; k++) begin
            issue($urandom, 3'($urandom), 1'($urandom), 1'($urandom));
            wait_idle();
        end

        check("bytes_drained", bytes_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tm1637_frame_sequencer.md
Name: tm1637_frame_sequencer

Overview:
- Sequences one complete TM1637 display refresh: three bus transactions (data-command, address plus 4 digit bytes, display-control), bit-banged on tm1637_clk/tm1637_dio.
- Sits between the demo top level (which supplies digit patterns and brightness) and the display pins.
- Owns bit timing, start/stop framing, and ACK checking.
- Exposes a req/busy/done handshake and a debug_step_id status bus.

Parameters:
- CLK_DIV, 250, clk_50M cycles per bus tick (half bit period). Minimum 2.

Ports:
- clk_50M  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req  input  1  start-frame request; sampled only in IDLE
- seg_data  input  32  digit bytes; d0=[7:0] … d3=[31:24]; latched on accept
- bright  input  3  brightness level; latched on accept
- disp_on  input  1  display enable; latched on accept
- tm1637_dio_in  input  1  DIO pin level (pulled up externally)
- tm1637_clk  output  1  TM1637 clock
- tm1637_dio_oe  output  1  1 = drive DIO low; 0 = release
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame end
- ack_err  output  1  a NACK was seen in the last frame
- debug_step_id  output  7  {txn[1:0], byte[2:0], phase[1:0]}; 7'h7F when idle

Behaviour:
- Reset values: tm1637_clk=1, tm1637_dio_oe=0, busy=0, done=0, ack_err=0, debug_step_id=7'h7F. Tick counter=0, FSM=IDLE.
- Reset asserted mid-frame aborts immediately to reset values. Outputs are not glitch-protected.
- Tick timing:
  - Divider counts 0..CLK_DIV-1 and runs only while busy.
  - Tick = the cycle where the counter equals CLK_DIV-1.
  - All pin outputs and the FSM update only on ticks.
- Accept:
  - req=1 in IDLE latches seg_data, bright and disp_on, clears ack_err, and sets busy the next cycle.
  - The divider starts from 0.
  - req while busy is ignored; no queuing.
- Phase codes: 0=START, 1=DATA, 2=ACK, 3=STOP.
- START (2 ticks): tick1 clk=1, oe=0; tick2 oe=1.
- DATA (8 bits, LSB first, 2 ticks per bit): tick a clk=0, oe=~bit; tick b clk=1.
- ACK (2 ticks): tick a clk=0, oe=0; tick b clk=1 and sample tm1637_dio_in. A sampled 1 sets ack_err (sticky until next accept). The frame continues regardless.
- STOP (3 ticks): clk=0, oe=1; then clk=1; then oe=0.
- Transactions:
  - txn0: START, byte 0x40, STOP.
  - txn1: START, byte 0xC0, d0, d1, d2, d3, STOP.
  - txn2: START, byte (disp_on ? 8'h88|bright : 8'h80), STOP.
  - Byte index counts 0.. within each txn; the command byte is index 0.
- Tick totals: txn0=23, txn1=95, txn2=23; frame=141 ticks.
- Completion:
  - On the final STOP tick of txn2: busy drops the following cycle and done pulses for exactly 1 cycle concurrently.
  - Accept-to-done latency = 141*CLK_DIV + 1 cycles.
  - Bus then idles at clk=1, oe=0.
- req high on the done cycle is not accepted; it is accepted on the first IDLE cycle after.
- debug_step_id updates on every tick.

Test Plan:
- Reset: rst pulse, no req → clk=1, oe=0, busy=0, done=0, debug_step_id=7'h7F held for 1000 cycles.
- Full frame, CLK_DIV=4, seg_data=32'h3F06_5B4F, bright=3'd7, disp_on=1, dio_in tied 0:
  - decoded byte stream 40 | C0 4F 5B 06 3F | 8F;
  - exactly 3 start and 3 stop conditions;
  - done exactly 565 cycles after accept;
  - ack_err=0.
- NACK: dio_in forced 1 only during the ACK of txn1 byte 2 → ack_err=1 after that sample; frame still completes with 7 bytes. Next req clears ack_err.
- Display off: disp_on=0, bright=5 → last byte 0x80.
- Busy lockout: req pulsed at cycle 100 of a frame → ignored; exactly one done; the second req after done starts a new frame.
- Reset mid-frame: rst during txn1 DATA → outputs return to reset values asynchronously; a following req yields a complete correct frame.
